// File: rtl/hack_mem_arbiter.sv
// hack_mem_arbiter
//   Shares the single Hack data Memory port between two request/ack masters:
//   port 0 (CPU data) and port 1 (loader/DMA). One access per 3-cycle window
//   (IDLE -> ACCESS -> DONE). Addresses above RAM_TOP are not RAM: reads
//   return 0, writes are suppressed and flagged on err.
//
//   Build option: define HACK_MEM_ARB_FIXED_PRIO_EN to make port 0 always win
//   contention. Otherwise contention is resolved round-robin.
//
// Ports
//   CLK, RST_N                      clock (rising edge), async active-low reset
//   reqN/weN/addrN/wdataN           port N request, held stable until ackN
//   ackN                            one-cycle completion pulse (DONE cycle)
//   rdataN                          read data, valid while ackN = 1
//   mem_in/mem_address/mem_load     to Memory
//   mem_out                         from Memory (combinational read)
//   busy                            high in ACCESS and DONE
//   gnt_id                          port currently or most recently granted
//   err                             pulse with ack for an out-of-range write
module hack_mem_arbiter #(
  parameter int unsigned ADDR_W  = 15,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned RAM_TOP = 16383
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] mem_in,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_load,
  input  logic [DATA_W-1:0] mem_out,
  output logic              busy,
  output logic              gnt_id,
  output logic              err
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  localparam logic [ADDR_W:0] TOP = (ADDR_W+1)'(RAM_TOP);

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mreq_t;

  logic [1:0]        state;
  mreq_t             lat;
  mreq_t             win_req;
  logic              win;
  logic              in_range;
  logic [DATA_W-1:0] rd_val;

  // Arbitration: a lone requester always wins; contention goes to port 0
  // (fixed) or to the port not granted last (round-robin).
  always_comb begin
    win = 1'b0;
`ifdef HACK_MEM_ARB_FIXED_PRIO_EN
    win = ~req0;
`else
    if (req0 && req1) win = ~gnt_id;
    else              win = req1;
`endif
    win_req.we    = win ? we1    : we0;
    win_req.addr  = win ? addr1  : addr0;
    win_req.wdata = win ? wdata1 : wdata0;
  end

  assign in_range = ({1'b0, lat.addr} <= TOP);
  assign rd_val   = (!lat.we && in_range) ? mem_out : '0;

  // The latched transaction only changes on the IDLE->ACCESS edge, so driving
  // Memory straight from it gives "valid in ACCESS, hold elsewhere" for free.
  assign mem_address = lat.addr;
  assign mem_in      = lat.wdata;
  // Decoded from state so an async reset mid-ACCESS drops it immediately.
  assign mem_load    = (state == S_ACCESS) && lat.we && in_range;
  assign busy        = (state != S_IDLE);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state  <= S_IDLE;
      lat    <= '0;
      gnt_id <= 1'b1;  // port 0 takes the first contention
      ack0   <= 1'b0;
      ack1   <= 1'b0;
      err    <= 1'b0;
      rdata0 <= '0;
      rdata1 <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req0 || req1) begin
            lat    <= win_req;
            gnt_id <= win;
            state  <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (gnt_id) begin
            ack1   <= 1'b1;
            rdata1 <= rd_val;
          end else begin
            ack0   <= 1'b1;
            rdata0 <= rd_val;
          end
          err   <= lat.we && !in_range;
          state <= S_DONE;
        end
        S_DONE: begin
          ack0  <= 1'b0;
          ack1  <= 1'b0;
          err   <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
